// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one memory port between fetch, data and debug,
// with fetch starvation promotion, a debug halt gate and a per-transaction timeout.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_halt,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr_rdata,
    output logic              instr_ready,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              resp_err,
    output logic [1:0]        grant_id
);
    // state | meaning
    // IDLE  | arbitrate eligible requests, register winner's command
    // ISSUE | mem_req high, wait for mem_ready or timeout
    // RESP  | one-cycle ready pulse to the winner
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [1:0] GNT_NONE  = 2'd0;
    localparam logic [1:0] GNT_INSTR = 2'd1;
    localparam logic [1:0] GNT_DATA  = 2'd2;
    localparam logic [1:0] GNT_DBG   = 2'd3;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   instr_rdata_q, instr_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic [1:0]          win;
    logic [DATA_W-1:0]   cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= GNT_NONE;
            starve_q      <= '0;
            tmo_q         <= '0;
            err_q         <= 1'b0;
            we_q          <= 1'b0;
            be_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            starve_q      <= starve_d;
            tmo_q         <= tmo_d;
            err_q         <= err_d;
            we_q          <= we_d;
            be_q          <= be_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
        end
    end

    // Fetch only outranks data once it has waited the full starvation limit.
    always_comb begin
        win = GNT_NONE;
        if (dbg_req) begin
            win = GNT_DBG;
        end else if (!dbg_halt) begin
            if (instr_req && starve_q == STARVE_MAX) win = GNT_INSTR;
            else if (data_req)                       win = GNT_DATA;
            else if (instr_req)                      win = GNT_INSTR;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!instr_req || (state_q == IDLE && win == GNT_INSTR) || gnt_q == GNT_INSTR)
            starve_d = '0;
        else if (!dbg_halt && starve_q != STARVE_MAX)
            starve_d = starve_q + SW'(1);
    end

    assign cap = mem_ready ? mem_rdata : '0;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        tmo_d         = tmo_q;
        err_d         = err_q;
        we_d          = we_q;
        be_d          = be_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (win != GNT_NONE) begin
                    state_d = ISSUE;
                    gnt_d   = win;
                    tmo_d   = '0;
                    case (win)
                        GNT_DBG: begin
                            we_d = dbg_we;  be_d = 4'hF;
                            addr_d = dbg_addr;  wdata_d = dbg_wdata;
                        end
                        GNT_DATA: begin
                            we_d = data_we; be_d = data_be;
                            addr_d = data_addr; wdata_d = data_wdata;
                        end
                        default: begin
                            we_d = 1'b0;    be_d = 4'hF;
                            addr_d = instr_addr; wdata_d = '0;
                        end
                    endcase
                end
            end
            ISSUE: begin
                // mem_ready in the final timeout cycle still counts as a normal response
                if (mem_ready || tmo_q == TMO_LAST) begin
                    state_d = RESP;
                    err_d   = ~mem_ready;
                    case (gnt_q)
                        GNT_INSTR: instr_rdata_d = cap;
                        GNT_DATA:  data_rdata_d  = cap;
                        GNT_DBG:   dbg_rdata_d   = cap;
                        default:   ;
                    endcase
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = GNT_NONE;
                tmo_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req     = (state_q == ISSUE);
    assign mem_we      = we_q;
    assign mem_be      = be_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign grant_id    = gnt_q;
    assign resp_err    = (state_q == RESP) && err_q;
    assign instr_ready = (state_q == RESP) && (gnt_q == GNT_INSTR);
    assign data_ready  = (state_q == RESP) && (gnt_q == GNT_DATA);
    assign dbg_ready   = (state_q == RESP) && (gnt_q == GNT_DBG);
    assign instr_rdata = instr_rdata_q;
    assign data_rdata  = data_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;
endmodule
